// File: rtl/branch_ctrl_if.sv
// Signal bundle between the branch controller and the IF/ID/EX pipeline.
// The slave side is the controller; the master side is the pipeline (or a bench).
interface branch_ctrl_if;
    logic [31:0] if_pc;
    logic        if_is_br;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_br;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_br;
    logic        ex_jump;
    logic        id_load_use;
    logic [1:0]  pc_sel;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic        mispredict;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    modport slave (
        input  if_pc, if_is_br, ex_valid, ex_is_br, ex_pc, ex_pred_taken,
               ex_br, ex_jump, id_load_use,
        output pred_taken, pc_sel, stall_if, stall_id, flush_id, flush_ex,
               mispredict, br_cnt, miss_cnt
    );

    modport master (
        output if_pc, if_is_br, ex_valid, ex_is_br, ex_pc, ex_pred_taken,
               ex_br, ex_jump, id_load_use,
        input  pred_taken, pc_sel, stall_if, stall_id, flush_id, flush_ex,
               mispredict, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch prediction (2-bit BHT), EX resolution, PC select / stall / flush and perf counters.
// Define BRANCH_BHT_PREDICT_EN to build the BHT; otherwise static not-taken prediction.
module branch_ctrl #(
    parameter  int BHT_ENTRIES = 16,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    branch_ctrl_if.slave  bus
);

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_res;
    logic             w_pred;
    logic             w_miss;
    logic             w_redirect;
    logic             w_unused;
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_miss_cnt;

    assign w_if_idx   = bus.if_pc[IDX_W+1:2];
    assign w_ex_idx   = bus.ex_pc[IDX_W+1:2];
    assign w_res      = bus.ex_valid & bus.ex_is_br;
    assign w_redirect = w_miss | (bus.ex_valid & bus.ex_jump);

    // PC bits outside the index field carry no information for this block.
    assign w_unused = ^{bus.if_pc, bus.ex_pc, bus.if_is_br, bus.ex_pred_taken,
                        w_if_idx, w_ex_idx};

`ifdef BRANCH_BHT_PREDICT_EN
    logic [1:0] r_bht [BHT_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (w_res) begin
            if (bus.ex_br && r_bht[w_ex_idx] != 2'b11)
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'd1;
            else if (!bus.ex_br && r_bht[w_ex_idx] != 2'b00)
                r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'd1;
        end
    end

    // Read sees the stored value; an EX update to the same entry lands at the edge.
    assign w_pred = bus.if_is_br & r_bht[w_if_idx][1];
    assign w_miss = w_res & (bus.ex_br != bus.ex_pred_taken);
`else
    assign w_pred = 1'b0;
    assign w_miss = w_res & bus.ex_br;
`endif

    always_comb begin
        bus.pc_sel   = 2'b00;
        bus.stall_if = 1'b0;
        bus.stall_id = 1'b0;
        bus.flush_id = 1'b0;
        bus.flush_ex = 1'b0;
        if (!rst) begin
            if (w_redirect) begin
                // A load-use stall here is moot: the ID instruction is being flushed.
                bus.flush_id = 1'b1;
                bus.flush_ex = 1'b1;
                bus.pc_sel   = (bus.ex_jump | bus.ex_br) ? 2'b10 : 2'b11;
            end else if (bus.id_load_use) begin
                bus.stall_if = 1'b1;
                bus.stall_id = 1'b1;
                bus.flush_ex = 1'b1;
            end else if (w_pred) begin
                bus.pc_sel   = 2'b01;
            end
        end
    end

    assign bus.pred_taken = ~rst & w_pred;
    assign bus.mispredict = ~rst & w_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_res)  r_br_cnt   <= r_br_cnt + 32'd1;
            if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign bus.br_cnt   = r_br_cnt;
    assign bus.miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; expectations follow the BRANCH_BHT_PREDICT_EN setting.
module tb_branch_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    branch_ctrl_if bus ();

    branch_ctrl #(.BHT_ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BRANCH_BHT_PREDICT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    task automatic idle();
        bus.if_pc         = 32'h0;
        bus.if_is_br      = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_is_br      = 1'b0;
        bus.ex_pc         = 32'h0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_br         = 1'b0;
        bus.ex_jump       = 1'b0;
        bus.id_load_use   = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br, input logic pt);
        bus.ex_valid      = 1'b1;
        bus.ex_is_br      = 1'b1;
        bus.ex_pc         = pc;
        bus.ex_br         = br;
        bus.ex_pred_taken = pt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        resolve(32'h40, 1'b1, 1'b0);
        bus.ex_jump = 1'b1; bus.id_load_use = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (bus.pc_sel !== 2'b00) begin n_fail++; $display("FAIL rst_pc_sel got %b want 00", bus.pc_sel); end
        n_chk++; if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b0) begin n_fail++; $display("FAIL rst_ctrl got %b want 0000", {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex}); end
        n_chk++; if ({bus.mispredict, bus.pred_taken} !== 2'b00) begin n_fail++; $display("FAIL rst_pred got %b want 00", {bus.mispredict, bus.pred_taken}); end
        n_chk++; if (bus.br_cnt !== 32'h0 || bus.miss_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_cnt got %h/%h want 0/0", bus.br_cnt, bus.miss_cnt); end
        @(negedge clk);
        rst = 1'b0;
        idle();
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        #1;
        n_chk++; if (bus.pred_taken !== 1'b0 || bus.pc_sel !== 2'b00) begin n_fail++; $display("FAIL post_rst_pred got %b/%b want 0/00", bus.pred_taken, bus.pc_sel); end
    endtask

    task automatic test_train_taken();
        @(negedge clk);
        idle();
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        resolve(32'h40, 1'b1, 1'b0);
        #1;
        n_chk++; if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL train1_miss got %b want 1", bus.mispredict); end
        n_chk++; if (bus.pc_sel !== 2'b10 || bus.flush_id !== 1'b1 || bus.flush_ex !== 1'b1) begin n_fail++; $display("FAIL train1_redir got %b %b%b want 10 11", bus.pc_sel, bus.flush_id, bus.flush_ex); end
        n_chk++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL train1_nobypass got %b want 0", bus.pred_taken); end
        @(negedge clk);
        idle();
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        #1;
        n_chk++; if (bus.pred_taken !== EN) begin n_fail++; $display("FAIL train1_entry got %b want %b", bus.pred_taken, EN); end
        @(negedge clk);
        resolve(32'h40, 1'b1, EN);
        #1;
        n_chk++; if (bus.mispredict !== !EN) begin n_fail++; $display("FAIL train2_miss got %b want %b", bus.mispredict, !EN); end
        @(negedge clk);
        idle();
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        #1;
        n_chk++; if (bus.pred_taken !== EN || bus.pc_sel !== (EN ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL train2_pred got %b/%b want %b/%b", bus.pred_taken, bus.pc_sel, EN, EN ? 2'b01 : 2'b00); end
        n_chk++; if (bus.br_cnt !== 32'd2 || bus.miss_cnt !== (EN ? 32'd1 : 32'd2)) begin n_fail++; $display("FAIL train_cnt got %0d/%0d want 2/%0d", bus.br_cnt, bus.miss_cnt, EN ? 1 : 2); end
        bus.if_pc = 32'h44;
        #1;
        n_chk++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL other_idx got %b want 0", bus.pred_taken); end
    endtask

    task automatic test_mispredict_nt();
        @(negedge clk);
        idle();
        resolve(32'h40, 1'b0, 1'b1);
        #1;
        n_chk++; if (bus.mispredict !== EN) begin n_fail++; $display("FAIL nt_miss got %b want %b", bus.mispredict, EN); end
        n_chk++; if (bus.pc_sel !== (EN ? 2'b11 : 2'b00) || bus.flush_id !== EN || bus.flush_ex !== EN) begin n_fail++; $display("FAIL nt_redir got %b %b%b want %b %b%b", bus.pc_sel, bus.flush_id, bus.flush_ex, EN ? 2'b11 : 2'b00, EN, EN); end
        @(negedge clk);
        idle();
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        #1;
        n_chk++; if (bus.pred_taken !== EN) begin n_fail++; $display("FAIL nt_weakT got %b want %b", bus.pred_taken, EN); end
        @(negedge clk);
        idle();
        resolve(32'h40, 1'b0, 1'b1);
        @(negedge clk);
        idle();
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        #1;
        n_chk++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt_weakNT got %b want 0", bus.pred_taken); end
        n_chk++; if (bus.br_cnt !== 32'd4 || bus.miss_cnt !== (EN ? 32'd3 : 32'd2)) begin n_fail++; $display("FAIL nt_cnt got %0d/%0d want 4/%0d", bus.br_cnt, bus.miss_cnt, EN ? 3 : 2); end
    endtask

    task automatic test_jump_priority();
        @(negedge clk);
        idle();
        bus.id_load_use = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_jump = 1'b1;
        #1;
        n_chk++; if (bus.pc_sel !== 2'b10) begin n_fail++; $display("FAIL jmp_pc_sel got %b want 10", bus.pc_sel); end
        n_chk++; if ({bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id} !== 4'b1100) begin n_fail++; $display("FAIL jmp_ctrl got %b want 1100", {bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id}); end
        n_chk++; if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL jmp_miss got %b want 0", bus.mispredict); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (bus.br_cnt !== 32'd4) begin n_fail++; $display("FAIL jmp_cnt got %0d want 4", bus.br_cnt); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        bus.id_load_use = 1'b1;
        bus.ex_is_br = 1'b1; bus.ex_br = 1'b1;
        #1;
        n_chk++; if ({bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id} !== 4'b1110) begin n_fail++; $display("FAIL lu_ctrl got %b want 1110", {bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id}); end
        n_chk++; if (bus.pc_sel !== 2'b00 || bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL lu_pc_sel got %b/%b want 00/0", bus.pc_sel, bus.mispredict); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (bus.br_cnt !== 32'd4) begin n_fail++; $display("FAIL bubble_cnt got %0d want 4", bus.br_cnt); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        idle();
        force dut.r_br_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_br_cnt;
        #1;
        resolve(32'h80, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (bus.br_cnt !== 32'h0) begin n_fail++; $display("FAIL wrap_br got %h want 00000000", bus.br_cnt); end
        n_chk++; if (bus.miss_cnt !== (EN ? 32'd3 : 32'd2)) begin n_fail++; $display("FAIL wrap_miss got %0d want %0d", bus.miss_cnt, EN ? 3 : 2); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        idle();
        resolve(32'h40, 1'b1, 1'b0);
        bus.if_pc = 32'h40; bus.if_is_br = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.br_cnt !== 32'h0 || bus.miss_cnt !== 32'h0) begin n_fail++; $display("FAIL midrst_cnt got %h/%h want 0/0", bus.br_cnt, bus.miss_cnt); end
        n_chk++; if (bus.mispredict !== 1'b0 || bus.pc_sel !== 2'b00 || bus.flush_id !== 1'b0) begin n_fail++; $display("FAIL midrst_out got %b/%b/%b want 0/00/0", bus.mispredict, bus.pc_sel, bus.flush_id); end
`ifdef BRANCH_BHT_PREDICT_EN
        for (int i = 0; i < 16; i++) begin
            n_chk++; if (dut.r_bht[i] !== 2'b01) begin n_fail++; $display("FAIL midrst_bht%0d got %b want 01", i, dut.r_bht[i]); end
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        n_chk++; if (bus.br_cnt !== 32'h0) begin n_fail++; $display("FAIL midrst_lost got %0d want 0", bus.br_cnt); end
        resolve(32'h48, 1'b1, 1'b0);
        @(negedge clk);
        idle();
        bus.if_pc = 32'h48; bus.if_is_br = 1'b1;
        #1;
        n_chk++; if (bus.pred_taken !== EN) begin n_fail++; $display("FAIL midrst_bht_init got %b want %b", bus.pred_taken, EN); end
        n_chk++; if (bus.br_cnt !== 32'd1 || bus.miss_cnt !== 32'd1) begin n_fail++; $display("FAIL midrst_recount got %0d/%0d want 1/1", bus.br_cnt, bus.miss_cnt); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_train_taken();
        test_mispredict_nt();
        test_jump_priority();
        test_load_use();
        test_wrap();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
